mem_arbiter: RTL and testbench

Single-port RAM arbiter between the pipeline's instruction fetch and data memory stages. It grants exactly one requester at a time. Data has priority, and a starvation counter bounds instruction-fetch delay. It returns the `ihit` and `dhit` pulses consumed by `hazard_unit`. A watchdog drives the block into a sticky error state when RAM stops responding.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM status encoding, arbiter state codes and defaults.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Plain constants keep the encoding visible to legacy tools and waveform viewers.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t IBUSY = 2'd1;
  localparam arb_state_t DBUSY = 2'd2;
  localparam arb_state_t FAULT = 2'd3;

  localparam int ARB_STARVE_LIMIT = 4;
  localparam int ARB_TIMEOUT      = 255;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch/data requester and single-port RAM signals seen by the memory arbiter.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dhit;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;
  logic        err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data-first with bounded fetch starvation, watchdog to sticky FAULT.
// Strobes one cycle after grant; hit in the ACCESS cycle; requesters hold their request until hit.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
  parameter int TIMEOUT      = ARB_TIMEOUT
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO   = 8'(TIMEOUT);

  arb_state_t  state;
  logic [3:0]  starve;
  logic [7:0]  wdog;
  logic [7:0]  wdog_inc;
  logic [31:0] req_addr;
  logic [31:0] req_store;
  logic        req_wen;
  logic        req_is_d;
  logic [31:0] iload_q;
  logic [31:0] dload_q;

  logic busy;
  logic access;
  logic data_req;
  logic ihit_w;
  logic dhit_w;

  assign busy     = (state == IBUSY) || (state == DBUSY);
  assign access   = busy && (bus.ramstate == ACCESS);
  assign data_req = bus.dREN || bus.dWEN;
  assign wdog_inc = wdog + 8'd1;

  // A flushed or withdrawn requester still lets the RAM cycle finish; only its hit is masked.
  assign ihit_w = access && !req_is_d && bus.iREN && (bus.iaddr == req_addr);
  assign dhit_w = access &&  req_is_d && data_req && (bus.daddr == req_addr);

  assign bus.ihit     = ihit_w;
  assign bus.dhit     = dhit_w;
  assign bus.iload    = ihit_w ? bus.ramload : iload_q;
  assign bus.dload    = dhit_w ? bus.ramload : dload_q;
  assign bus.ramREN   = busy && !req_wen;
  assign bus.ramWEN   = busy &&  req_wen;
  assign bus.ramaddr  = req_addr;
  assign bus.ramstore = req_store;
  assign bus.err      = (state == FAULT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      starve    <= '0;
      wdog      <= '0;
      req_addr  <= '0;
      req_store <= '0;
      req_wen   <= 1'b0;
      req_is_d  <= 1'b0;
      iload_q   <= '0;
      dload_q   <= '0;
    end else begin
      if (ihit_w) iload_q <= bus.ramload;
      if (dhit_w) dload_q <= bus.ramload;

      case (state)
        IDLE: begin
          if (data_req && !(bus.iREN && starve == LIMIT)) begin
            state     <= DBUSY;
            req_addr  <= bus.daddr;
            req_store <= bus.dstore;
            req_wen   <= bus.dWEN;
            req_is_d  <= 1'b1;
            wdog      <= '0;
            starve    <= bus.iREN ? sat_inc4(starve, LIMIT) : 4'd0;
          end else if (bus.iREN) begin
            state     <= IBUSY;
            req_addr  <= bus.iaddr;
            req_wen   <= 1'b0;
            req_is_d  <= 1'b0;
            wdog      <= '0;
            starve    <= '0;
          end else begin
            starve    <= '0;
          end
        end

        IBUSY, DBUSY: begin
          if (bus.ramstate == ACCESS) begin
            state <= IDLE;
          end else if (bus.ramstate == ERROR || wdog_inc == TMO) begin
            state <= FAULT;
          end else begin
            wdog  <= wdog_inc;
          end
        end

        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic against a cycle-level behavioural model of the arbiter.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT = 4;
  localparam int TMO   = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: who owns the RAM (0 none, 1 fetch, 2 data, 3 fault) and what it was granted.
  int          m_owner;
  logic [31:0] m_addr, m_store, m_iload, m_dload;
  bit          m_wen;
  int          m_starve;
  int          m_busy_cycles;

  // Values seen at the last sample point, for directed checks and requester reactions.
  bit          o_ren, o_wen, o_ihit, o_dhit, o_err;
  logic [31:0] o_addr, o_store, o_iload;
  bit          x_ihit, x_dhit;

  task automatic model_reset();
    m_owner = 0; m_addr = '0; m_store = '0; m_iload = '0; m_dload = '0;
    m_wen = 1'b0; m_starve = 0; m_busy_cycles = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = FREE;
    #2;
    check("rst_ramREN",   32'(bus.ramREN), 32'd0);
    check("rst_ramWEN",   32'(bus.ramWEN), 32'd0);
    check("rst_ihit",     32'(bus.ihit),   32'd0);
    check("rst_dhit",     32'(bus.dhit),   32'd0);
    check("rst_err",      32'(bus.err),    32'd0);
    check("rst_ramaddr",  bus.ramaddr,     32'd0);
    check("rst_ramstore", bus.ramstore,    32'd0);
    check("rst_iload",    bus.iload,       32'd0);
    check("rst_dload",    bus.dload,       32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock: sample and compare at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    bit busy, acc, dreq;
    @(negedge clk);
    busy = (m_owner == 1) || (m_owner == 2);
    acc  = busy && (bus.ramstate == ACCESS);
    x_ihit = acc && (m_owner == 1) && bus.iREN && (bus.iaddr == m_addr);
    x_dhit = acc && (m_owner == 2) && (bus.dREN || bus.dWEN) && (bus.daddr == m_addr);
    if (x_ihit) m_iload = bus.ramload;
    if (x_dhit) m_dload = bus.ramload;

    check("ramREN", 32'(bus.ramREN), 32'(busy && !m_wen));
    check("ramWEN", 32'(bus.ramWEN), 32'(busy && m_wen));
    if (busy) check("ramaddr", bus.ramaddr, m_addr);
    if (busy && m_wen) check("ramstore", bus.ramstore, m_store);
    check("ihit",  32'(bus.ihit), 32'(x_ihit));
    check("dhit",  32'(bus.dhit), 32'(x_dhit));
    check("iload", bus.iload, m_iload);
    check("dload", bus.dload, m_dload);
    check("err",   32'(bus.err), 32'(m_owner == 3));

    o_ren = bus.ramREN; o_wen = bus.ramWEN; o_ihit = bus.ihit; o_dhit = bus.dhit;
    o_err = bus.err; o_addr = bus.ramaddr; o_store = bus.ramstore; o_iload = bus.iload;

    dreq = bus.dREN || bus.dWEN;
    case (m_owner)
      0: begin
        if (dreq && !(bus.iREN && m_starve == LIMIT)) begin
          m_owner = 2; m_addr = bus.daddr; m_store = bus.dstore; m_wen = bus.dWEN;
          m_busy_cycles = 0;
          m_starve = bus.iREN ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
        end else if (bus.iREN) begin
          m_owner = 1; m_addr = bus.iaddr; m_wen = 1'b0; m_busy_cycles = 0; m_starve = 0;
        end else begin
          m_starve = 0;
        end
      end
      1, 2: begin
        if (acc) m_owner = 0;
        else begin
          m_busy_cycles++;
          if (bus.ramstate == ERROR || m_busy_cycles >= TMO) m_owner = 3;
        end
      end
      default: ;
    endcase
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int n, g;
    bit prev;
    int r;

    // Lone fetch
    do_reset();
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    cycle();
    bus.ramstate = BUSY;
    cycle();
    check("fetch_ren",  32'(o_ren), 32'd1);
    check("fetch_addr", o_addr, 32'h40);
    cycle();
    bus.ramstate = ACCESS; bus.ramload = 32'h8C220004;
    cycle();
    check("fetch_ihit",  32'(o_ihit), 32'd1);
    check("fetch_iload", o_iload, 32'h8C220004);
    bus.iREN = 1'b0; bus.ramstate = FREE;
    cycle();
    check("fetch_turn", 32'(o_ren), 32'd0);
    check("fetch_once", 32'(o_ihit), 32'd0);

    // Contention: write wins, fetch follows the turnaround
    do_reset();
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD;
    cycle();
    bus.ramstate = ACCESS;
    cycle();
    check("cont_wen",   32'(o_wen), 32'd1);
    check("cont_ren",   32'(o_ren), 32'd0);
    check("cont_store", o_store, 32'hDEAD);
    check("cont_dhit",  32'(o_dhit), 32'd1);
    bus.dWEN = 1'b0; bus.ramstate = FREE;
    cycle();
    check("cont_turn", 32'(o_ren || o_wen), 32'd0);
    bus.ramstate = ACCESS; bus.ramload = 32'h1234;
    cycle();
    check("cont_igrant", 32'(o_ren), 32'd1);
    check("cont_iaddr",  o_addr, 32'h40);
    check("cont_ihit",   32'(o_ihit), 32'd1);
    bus.iREN = 1'b0; bus.ramstate = FREE;
    cycle();

    // Starvation: 4 data grants then 1 fetch grant, repeating
    do_reset();
    bus.iREN = 1'b1; bus.iaddr = 32'h300;
    bus.dREN = 1'b1; bus.daddr = 32'h400;
    bus.ramstate = ACCESS;
    g = 0; prev = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.ramload = $urandom;
      cycle();
      if ((o_ren || o_wen) && !prev) begin
        check($sformatf("starve_g%0d", g), o_addr, (g % 5 == 4) ? 32'h300 : 32'h400);
        g++;
      end
      prev = o_ren || o_wen;
    end
    check("starve_count", 32'(g), 32'd20);
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
    cycle();

    // Flush: redirected fetch completes silently, next grant uses new address
    do_reset();
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
    cycle();
    cycle();
    bus.iaddr = 32'h80; bus.ramstate = ACCESS; bus.ramload = 32'h5555;
    cycle();
    check("flush_ren",  32'(o_ren), 32'd1);
    check("flush_addr", o_addr, 32'h40);
    check("flush_ihit", 32'(o_ihit), 32'd0);
    bus.ramstate = FREE;
    cycle();
    bus.ramstate = ACCESS; bus.ramload = 32'h6666;
    cycle();
    check("flush_next", o_addr, 32'h80);
    check("flush_hit",  32'(o_ihit), 32'd1);
    bus.iREN = 1'b0; bus.ramstate = FREE;
    cycle();

    // Watchdog timeout
    do_reset();
    bus.dREN = 1'b1; bus.daddr = 32'h200;
    cycle();
    bus.ramstate = BUSY;
    n = 0;
    for (int c = 0; c < 300 && !o_err; c++) begin
      cycle();
      if (o_ren) n++;
    end
    check("tmo_cycles", 32'(n), 32'd255);
    check("tmo_err", 32'(o_err), 32'd1);
    bus.ramstate = ACCESS;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("tmo_sticky", 32'(o_err), 32'd1);
      check("tmo_strobe", 32'(o_ren || o_wen), 32'd0);
    end

    // RAM error mid-DBUSY, then reset out of the fault
    do_reset();
    bus.dWEN = 1'b1; bus.daddr = 32'h500; bus.dstore = 32'h77;
    cycle();
    bus.ramstate = BUSY;
    cycle();
    bus.ramstate = ERROR;
    cycle();
    bus.ramstate = FREE;
    cycle();
    check("rerr_flag", 32'(o_err), 32'd1);
    check("rerr_wen",  32'(o_wen), 32'd0);
    do_reset();

    // Reset during the ACCESS cycle issues no hit
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    cycle();
    bus.ramstate = ACCESS; bus.ramload = 32'hAA;
    rst = 1'b1;
    #2;
    check("rst_mid_ihit", 32'(bus.ihit), 32'd0);
    check("rst_mid_ren",  32'(bus.ramREN), 32'd0);
    do_reset();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      cycle();
      if (bus.iREN) begin
        if (x_ihit) begin
          bus.iREN = 1'($urandom_range(0, 1)); bus.iaddr = rand_addr();
        end else begin
          r = $urandom_range(0, 99);
          if (r < 4) bus.iaddr = rand_addr();
          else if (r < 6) bus.iREN = 1'b0;
        end
      end else if ($urandom_range(0, 99) < 40) begin
        bus.iREN = 1'b1; bus.iaddr = rand_addr();
      end

      if (bus.dREN || bus.dWEN) begin
        r = $urandom_range(0, 99);
        if (x_dhit) begin
          bus.dREN = 1'b0; bus.dWEN = 1'b0;
        end else if (r < 4) begin
          bus.daddr = rand_addr();
        end else if (r < 6) begin
          bus.dREN = 1'b0; bus.dWEN = 1'b0;
        end
      end else if ($urandom_range(0, 99) < 40) begin
        r = $urandom_range(0, 99);
        bus.dREN = (r < 45) || (r >= 90);
        bus.dWEN = (r >= 45);
        bus.daddr = rand_addr();
        bus.dstore = $urandom;
      end

      bus.ramload = $urandom;
      if (m_owner == 1 || m_owner == 2)
        bus.ramstate = ($urandom_range(0, 99) < 40) ? ACCESS : BUSY;
      else
        bus.ramstate = ramstate_t'($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
